deck_dealer: RTL
================

Name: deck_dealer

Overview:
- Card source that sits directly upstream of the baccarat datapath.
- Models a single 52-card shoe without replacement, so no card is dealt twice before a shuffle.
- On a one-cycle draw request it returns a rank of 1..13, where 1=A, 11=J, 12=Q, 13=K. The datapath latches that rank into the pcard/dcard register selected by its load signal.
- Runs on fast_clock. The request/acknowledge handshake replaces the free-running dealcard counter.

Parameters:
- SEED, 16'hACE1, LFSR seed loaded at reset. Must be nonzero; a zero value is replaced by 16'h0001.

Ports:
- fast_clock  input   1  system clock (CLOCK_50 domain)
- resetb      input   1  reset, asynchronous, active-low
- draw_req    input   1  single-cycle pulse: deal one card
- shuffle     input   1  single-cycle pulse: return all 52 cards to the shoe
- card        output  4  rank of the last dealt card, 1..13; 0 = no card or shoe empty
- draw_ack    output  1  one-cycle pulse: card is valid
- busy        output  1  high while a draw is in progress (SEARCH or ACK)
- cards_left  output  6  cards remaining, 52..0
- deck_empty  output  1  high when cards_left == 0 (combinational decode)

Behaviour:
- Reset (resetb low, asynchronous), all values held until resetb rises:
  - state=IDLE
  - used mask (52 bits)=0
  - cards_left=52
  - card=0, draw_ack=0, busy=0
  - lfsr=SEED
  - shuffle_pend=0
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts right.
  - Advances on every fast_clock edge regardless of state.
- Index derivation: idx0 = lfsr[5:0] when < 52, else lfsr[5:0] − 52. This always yields 0..51.
- Rank mapping: rank = (idx mod 13) + 1, so each rank appears exactly 4 times in the shoe.
- States are IDLE, SEARCH, ACK.
- IDLE:
  - shuffle=1 (or shuffle_pend=1): mask←0, cards_left←52, shuffle_pend←0. A draw_req in the same cycle is dropped; shuffle wins.
  - Otherwise draw_req=1 with cards_left>0: idx←idx0, go to SEARCH.
  - Otherwise draw_req=1 with cards_left==0: card←0, go to ACK. The empty shoe is reported as an ack carrying card 0.
- SEARCH, evaluated on each edge:
  - If mask[idx]==0: mask[idx]←1, cards_left←cards_left−1, card←rank(idx), go to ACK.
  - Otherwise idx←(idx==51)?0:idx+1 and stay in SEARCH.
  - At most 52 probes are needed, because cards_left>0 guarantees a free slot.
- ACK: draw_ack=1 for exactly this one cycle, then return to IDLE.
- busy=1 in SEARCH and ACK.
- Latency: draw_req sampled at edge E0 gives draw_ack high during the cycle after edge E(1+m), where m = number of occupied slots skipped. A fresh shoe gives ack 2 cycles after the request.
- card holds its value until the next ack or until reset. It does not change on shuffle.
- draw_req while busy=1 is ignored. It is not queued, and no ack results from it.
- shuffle while busy=1 sets shuffle_pend. The pending shuffle is applied in the first IDLE cycle, and the in-flight draw completes normally first.
- cards_left never underflows. It decrements only in SEARCH on a hit.
- Reset mid-SEARCH or mid-ACK aborts the draw immediately: no ack, and all reset values apply.

Test Plan:
1. Reset then idle 10 cycles → card=0, draw_ack=0, busy=0, cards_left=52, deck_empty=0.
2. 52 draw_req pulses, each issued after the previous ack → 52 acks. Each of ranks 1..13 is seen exactly 4 times. Every card is in 1..13. cards_left ends at 0 and deck_empty=1. The bench's LFSR reference model matches every rank.
3. With the shoe empty, pulse draw_req → ack 1 cycle later with card=0 and cards_left=0. Then pulse shuffle → next cycle cards_left=52, deck_empty=0.
4. Pulse draw_req, then a second draw_req and a shuffle while busy=1 → exactly one ack, and cards_left=51 at ack. The pending shuffle then restores cards_left=52 in the first IDLE cycle.
5. Assert draw_req and shuffle in the same IDLE cycle → no ack and cards_left=52. The draw is dropped.
6. Fill 40 cards, pulse draw_req, then drop resetb during SEARCH → no draw_ack, cards_left=52, card=0 asynchronously. After release, the first draw acks in 2 cycles.

Source files
------------

// File: rtl/deck_dealer.sv
// deck_dealer: single 52-card shoe; deals ranks 1..13 without replacement,
// starting each draw at an LFSR-chosen slot and probing linearly for a free card.
module deck_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       fast_clock,
    input  logic       resetb,
    input  logic       draw_req,
    input  logic       shuffle,
    output logic [3:0] card,
    output logic       draw_ack,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       deck_empty
);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {IDLE, SEARCH, ACK} state_t;

    state_t      state_q, state_d;
    logic [51:0] mask_q, mask_d;
    logic [5:0]  left_q, left_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  card_q, card_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        pend_q, pend_d;
    logic [5:0]  idx0;
    logic        hit;
    logic        clear;

    assign idx0  = (lfsr_q[5:0] >= 6'd52) ? lfsr_q[5:0] - 6'd52 : lfsr_q[5:0];
    assign hit   = !mask_q[idx_q];
    assign clear = shuffle || pend_q;

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            mask_q  <= '0;
            left_q  <= 6'd52;
            idx_q   <= '0;
            card_q  <= '0;
            lfsr_q  <= SEED_NZ;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            left_q  <= left_d;
            idx_q   <= idx_d;
            card_q  <= card_d;
            lfsr_q  <= lfsr_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (clear || !draw_req) ? IDLE : (left_q != 6'd0) ? SEARCH : ACK;
            SEARCH:  state_d = hit ? ACK : SEARCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        mask_d = mask_q;
        left_d = left_q;
        idx_d  = idx_q;
        card_d = card_q;
        // A shuffle arriving mid-draw is remembered and applied once back in IDLE
        pend_d = pend_q || (shuffle && state_q != IDLE);
        if (state_q == IDLE && clear) begin
            mask_d = '0;
            left_d = 6'd52;
            pend_d = 1'b0;
        end else if (state_q == IDLE && draw_req) begin
            idx_d  = idx0;
            card_d = (left_q == 6'd0) ? 4'd0 : card_q;
        end else if (state_q == SEARCH && hit) begin
            mask_d[idx_q] = 1'b1;
            left_d        = left_q - 6'd1;
            card_d        = 4'(idx_q % 6'd13 + 6'd1);
        end else if (state_q == SEARCH) begin
            idx_d = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
        end
    end

    always_comb begin
        busy     = state_q != IDLE;
        draw_ack = state_q == ACK;
    end

    assign card       = card_q;
    assign cards_left = left_q;
    assign deck_empty = left_q == 6'd0;
endmodule
